// File: rtl/adc_8bit.sv
// adc_8bit: flash ADC model, 255 comparators into a thermometer code, then a registered priority encoder
module adc_8bit (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  input  logic [7:0] Vin,
  input  logic [7:0] Vref,
  output logic [7:0] digital_out,
  output logic       out_valid,
  output logic       over_range
);
  localparam int NCOMP = 255;
  logic [NCOMP-1:0] therm, therm_q;
  logic             or_q, v_q;
  logic [7:0]       enc;
  // Vin*256 >= k*Vref compared at full 16-bit width, so Vref=0 trips every level
  for (genvar k = 1; k <= NCOMP; k++) begin : g_cmp
    assign therm[k-1] = {Vin, 8'h00} >= 16'(k) * {8'h00, Vref};
  end
  always_comb begin
    enc = '0;
    for (int i = 0; i < NCOMP; i++) enc = therm_q[i] ? 8'(i + 1) : enc;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      therm_q <= '0;
      or_q    <= 1'b0;
      v_q     <= 1'b0;
    end else begin
      v_q <= in_valid;
      if (in_valid) begin
        therm_q <= therm;
        or_q    <= Vin >= Vref;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      digital_out <= '0;
      over_range  <= 1'b0;
      out_valid   <= 1'b0;
    end else begin
      out_valid <= v_q;
      if (v_q) begin
        digital_out <= enc;
        over_range  <= or_q;
      end
    end
  end
endmodule

// File: tb/tb_adc_8bit.sv
// tb_adc_8bit: vector table plus scoreboard queue checking adc_8bit results and pipeline timing
module tb_adc_8bit;
  logic       clk = 0, rst_n = 0, in_valid = 0;
  logic [7:0] Vin = 0, Vref = 0;
  logic [7:0] digital_out;
  logic       out_valid, over_range;
  int compared = 0, mismatched = 0;

  typedef struct { logic [7:0] vin, vref, dout; logic ovr; } vec_t;
  typedef struct { logic [7:0] dout; logic ovr; } exp_t;
  exp_t q[$];

  adc_8bit dut (.clk(clk), .rst_n(rst_n), .in_valid(in_valid), .Vin(Vin), .Vref(Vref),
                .digital_out(digital_out), .out_valid(out_valid), .over_range(over_range));

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input int act, input int exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic exp_t model(input int vin, input int vref);
    exp_t e;
    int d;
    d = (vref == 0) ? 255 : (vin * 256) / vref;
    e.dout = 8'((d > 255) ? 255 : d);
    e.ovr = vin >= vref;
    return e;
  endfunction

  // Results become visible just after the edge; compare them against the oldest pending sample
  always @(posedge clk) begin
    #1;
    if (out_valid === 1'b1) begin
      if (q.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL unexpected_out_valid: got 1 expected 0 (no pending sample)");
      end else begin
        exp_t e;
        e = q.pop_front();
        check("digital_out", digital_out, e.dout);
        check("over_range", over_range, e.ovr);
      end
    end
  end

  task automatic step(input logic rst, input logic iv, input logic [7:0] vin, input logic [7:0] vref);
    @(negedge clk);
    rst_n = rst; in_valid = iv; Vin = vin; Vref = vref;
    if (!rst) q.delete();
    else if (iv) q.push_back(model(vin, vref));
  endtask

  vec_t tbl[$];
  logic pat[9] = '{1, 0, 0, 1, 1, 0, 0, 0, 0};
  logic [7:0] held;

  initial begin
    tbl = '{
      '{8'd6, 8'd18, 8'd85, 1'b0},   '{8'd7, 8'd18, 8'd99, 1'b0},   '{8'd8, 8'd18, 8'd113, 1'b0},
      '{8'd9, 8'd18, 8'd128, 1'b0},  '{8'd10, 8'd18, 8'd142, 1'b0}, '{8'd11, 8'd18, 8'd156, 1'b0},
      '{8'd12, 8'd18, 8'd170, 1'b0}, '{8'd13, 8'd18, 8'd184, 1'b0}, '{8'd14, 8'd18, 8'd199, 1'b0},
      '{8'd15, 8'd18, 8'd213, 1'b0}, '{8'd16, 8'd18, 8'd227, 1'b0}, '{8'd17, 8'd18, 8'd241, 1'b0},
      '{8'd18, 8'd18, 8'd255, 1'b1}, '{8'd1, 8'd10, 8'd25, 1'b0},   '{8'd5, 8'd10, 8'd128, 1'b0},
      '{8'd9, 8'd10, 8'd230, 1'b0},  '{8'd10, 8'd10, 8'd255, 1'b1}, '{8'd20, 8'd10, 8'd255, 1'b1},
      '{8'd0, 8'd200, 8'd0, 1'b0},   '{8'd255, 8'd255, 8'd255, 1'b1}, '{8'd254, 8'd255, 8'd254, 1'b0},
      '{8'd0, 8'd0, 8'd255, 1'b1},   '{8'd77, 8'd0, 8'd255, 1'b1}
    };
    // Reset held two edges with a valid-looking sample present
    step(0, 1, 200, 100);
    step(0, 1, 200, 100);
    @(negedge clk);
    check("reset_digital_out", digital_out, 0);
    check("reset_out_valid", out_valid, 0);
    check("reset_over_range", over_range, 0);
    rst_n = 1; in_valid = 1; Vin = 100; Vref = 200;
    q.push_back(model(100, 200));
    step(1, 0, 0, 0);
    check("first_latency_early", out_valid, 0);
    step(1, 0, 0, 0);
    check("first_latency_on_time", out_valid, 1);
    // Table entries carry hand-derived results; also mirror each through the scoreboard
    foreach (tbl[i]) begin
      step(1, 1, tbl[i].vin, tbl[i].vref);
      q[$] = '{tbl[i].dout, tbl[i].ovr};
    end
    repeat (4) step(1, 0, 0, 0);
    for (int i = 0; i < 40; i++)
      step(1, 1, 8'($urandom_range(0, 255)), 8'((i % 8 == 0) ? 0 : $urandom_range(1, 255)));
    repeat (4) step(1, 0, 0, 0);
    // Gapped stream: out_valid at negedge j mirrors the sample driven two negedges earlier
    for (int j = 0; j < 11; j++) begin
      @(negedge clk);
      check("gapped_out_valid", out_valid, (j >= 2) ? pat[j-2] : 1'b0);
      if (j >= 2 && !pat[j-2] && j != 2) check("gapped_hold", digital_out, held);
      held = digital_out;
      in_valid = (j < 9) ? pat[j] : 1'b0;
      Vin = 8'(40 + j * 20); Vref = 8'd150;
      if (in_valid) q.push_back(model(Vin, Vref));
    end
    // Reset arrives one cycle after a sample is accepted; that sample must vanish
    step(1, 1, 100, 200);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    check("midreset_out_valid", out_valid, 0);
    check("midreset_digital_out", digital_out, 0);
    check("midreset_over_range", over_range, 0);
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    check("midreset_no_late_pulse", out_valid, 0);
    // Inputs wiggling without in_valid must not disturb the outputs
    step(1, 0, 255, 1);
    step(1, 0, 3, 0);
    step(1, 0, 0, 0);
    check("no_valid_digital_out", digital_out, 0);
    check("no_valid_out_valid", out_valid, 0);
    check("drained_queue", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
